// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/write-back interface of the multiply/divide unit
// Purpose: bundles the operand request handshake and the register-file
//          write-port outputs of mul_div_unit.
// Signals: in_valid/in_ready request handshake, op/src_a/src_b/rd operands,
//          flush abort, busy status, wb_we/wb_rd/wb_data write-back (WE3/AD3/WD3).
// Modports: master drives requests (issue stage), slave is the unit itself.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               op;
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     flush;
    logic                     busy;
    logic                     wb_we;
    logic [ADDRESS_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]    wb_data;

    modport master (
        output in_valid, op, src_a, src_b, rd, flush,
        input  in_ready, busy, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, op, src_a, src_b, rd, flush,
        output in_ready, busy, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 unsigned multiply/divide unit
// Purpose: one bit per cycle shift-add multiplier and restoring divider,
//          one operation in flight, result delivered in register-file
//          write-port form.
// Ports:   clk    rising-edge clock
//          rst_n  asynchronous active-low reset
//          bus    mul_div_unit_if.slave: in_valid/in_ready, op (00 MUL,
//                 01 MULHU, 10 DIVU, 11 REMU), src_a, src_b, rd, flush,
//                 busy, wb_we, wb_rd, wb_data
module mul_div_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [1:0]               op_q, op_d;
    logic [W-1:0]             a_q, a_d;
    logic [W-1:0]             b_q, b_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    // hi: upper product half / partial remainder; lo: multiplier / dividend-quotient
    logic [W:0]               hi_q, hi_d;
    logic [W-1:0]             lo_q, lo_d;
    logic [ADDRESS_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [W-1:0]             wb_data_q, wb_data_d;

    logic       is_div;
    logic [W:0] mul_sum;
    logic [W:0] rem_sh;
    logic [W:0] rem_sub;
    logic       rem_ge;
    logic [W:0] iter_hi;
    logic [W-1:0] iter_lo;

    // State register (all flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid && !bus.flush) state_d = S_BUSY;
            S_BUSY: begin
                if (bus.flush)               state_d = S_IDLE;
                else if (count_q == LAST_CNT) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One radix-2 step for each operation class
    always_comb begin
        is_div  = op_q[1];
        // hi_q[W] is always zero in multiply mode, so the sum never wraps
        mul_sum = hi_q + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        rem_sh  = {hi_q[W-1:0], lo_q[W-1]};
        rem_ge  = (rem_sh >= {1'b0, b_q});
        rem_sub = rem_sh - {1'b0, b_q};
        if (is_div) begin
            iter_hi = rem_ge ? rem_sub : rem_sh;
            iter_lo = {lo_q[W-2:0], rem_ge};
        end else begin
            iter_hi = {1'b0, mul_sum[W:1]};
            iter_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    // Datapath register updates
    always_comb begin
        count_d   = count_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d    = bus.op;
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    rd_d    = bus.rd;
                    hi_d    = '0;
                    count_d = '0;
                end
            end
            S_BUSY: begin
                if (!bus.flush) begin
                    count_d = count_q + 1'b1;
                    if (count_q == '0) begin
                        // Setup step: seed the working registers from the
                        // captured operands; iterations run at counts 1..W.
                        hi_d = '0;
                        lo_d = is_div ? a_q : b_q;
                    end else begin
                        hi_d = iter_hi;
                        lo_d = iter_lo;
                        if (count_q == LAST_CNT) begin
                            wb_rd_d = rd_q;
                            case (op_q)
                                OP_MUL:   wb_data_d = iter_lo;
                                OP_MULHU: wb_data_d = iter_hi[W-1:0];
                                OP_DIVU:  wb_data_d = iter_lo;
                                OP_REMU:  wb_data_d = iter_hi[W-1:0];
                                default:  wb_data_d = wb_data_q;
                            endcase
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready = (state_q == S_IDLE);
        bus.busy     = (state_q != S_IDLE);
        // x0 is never written; a flush in DONE drops the pulse
        bus.wb_we    = (state_q == S_DONE) && (wb_rd_q != '0) && !bus.flush;
        bus.wb_rd    = wb_rd_q;
        bus.wb_data  = wb_data_q;
    end
endmodule
